// File: rtl/div_array_arbiter.sv
// div_array_arbiter: round-robin controller sharing one combinational 16/8 divider array.
// Optional DIV_ARB_OVF_CHECK_EN adds the registered rsp_ovf quotient-overflow flag.
module div_array_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [16*NREQ-1:0] req_n,
    input  logic [8*NREQ-1:0] req_d,
    output logic [15:0]       div_n,
    output logic [7:0]        div_d,
    input  logic [7:0]        div_q,
    input  logic [7:0]        div_r,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_q,
    output logic [7:0]        rsp_r,
    output logic              rsp_dbz
`ifdef DIV_ARB_OVF_CHECK_EN
    ,
    output logic              rsp_ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [3:0]     cnt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] idx;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [15:0]    gnt_n;
    logic [7:0]     gnt_d;
    logic           gnt_dbz;
    logic           hs_req;

    // Round-robin search: lowest offset from ptr+1 wins, so scan offsets downward.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        gnt_n = '0;
        gnt_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                gnt_n = req_n[16*i +: 16];
                gnt_d = req_d[8*i +: 8];
            end
        end
    end

    // A grant in IDLE is always a handshake since the winner's valid is high;
    // held off during reset so no requester sees a phantom accept.
    assign gnt_dbz = (gnt_d == 8'd0);
    assign hs_req  = (state == S_IDLE) && gnt_found && rst_n;

    // Accept strobe goes to the single granted requester.
    always_comb begin
        req_ready = '0;
        if (hs_req) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign rsp_valid = (state == S_RESP);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (hs_req) begin
                    state_nxt = gnt_dbz ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Launch, settle counter and result capture; array inputs move only on a launch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr     <= IDW'(NREQ - 1);
            cnt     <= '0;
            div_n   <= '0;
            div_d   <= '0;
            rsp_id  <= '0;
            rsp_q   <= '0;
            rsp_r   <= '0;
            rsp_dbz <= 1'b0;
        end else if (hs_req) begin
            ptr    <= gnt_idx;
            rsp_id <= gnt_idx;
            if (gnt_dbz) begin
                rsp_q   <= 8'hFF;
                rsp_r   <= gnt_n[7:0];
                rsp_dbz <= 1'b1;
            end else begin
                div_n   <= gnt_n;
                div_d   <= gnt_d;
                cnt     <= 4'(LAT - 1);
                rsp_dbz <= 1'b0;
            end
        end else if (state == S_BUSY) begin
            if (cnt == 4'd0) begin
                rsp_q <= div_q;
                rsp_r <= div_r;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

`ifdef DIV_ARB_OVF_CHECK_EN
    // Quotient will not fit in 8 bits when the high dividend byte reaches d.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_ovf <= 1'b0;
        end else if (hs_req) begin
            rsp_ovf <= !gnt_dbz && (gnt_n[15:8] >= gnt_d);
        end
    end
`endif

endmodule

// File: tb/tb_div_array_arbiter.sv
// tb_div_array_arbiter: random and directed checks of div_array_arbiter
// against a transaction-level model with a stub divider array.
module tb_div_array_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 2;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [16*NREQ-1:0]   req_n;
    logic [8*NREQ-1:0]    req_d;
    logic [15:0]          div_n;
    logic [7:0]           div_d;
    logic [7:0]           div_q;
    logic [7:0]           div_r;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [7:0]           rsp_q;
    logic [7:0]           rsp_r;
    logic                 rsp_dbz;
`ifdef DIV_ARB_OVF_CHECK_EN
    logic                 rsp_ovf;
`endif

    always #5 clk = ~clk;

    div_array_arbiter #(
        .NREQ(NREQ),
        .LAT (LAT),
        .IDW (IDW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_n    (req_n),
        .req_d    (req_d),
        .div_n    (div_n),
        .div_d    (div_d),
        .div_q    (div_q),
        .div_r    (div_r),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_q    (rsp_q),
        .rsp_r    (rsp_r),
        .rsp_dbz  (rsp_dbz)
`ifdef DIV_ARB_OVF_CHECK_EN
        ,
        .rsp_ovf  (rsp_ovf)
`endif
    );

    // Stub divider array.
    logic [15:0] stub_q16;
    always_comb begin
        stub_q16 = '0;
        div_r    = '0;
        if (div_d != 8'd0) begin
            stub_q16 = div_n / {8'd0, div_d};
            div_r    = 8'(div_n % {8'd0, div_d});
        end
        div_q = stub_q16[7:0];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model state.
    bit          pend [NREQ];
    logic [15:0] pn   [NREQ];
    logic [7:0]  pd   [NREQ];
    bit          busy;
    int          cyc;
    int          rsp_at;
    int          hs_cyc;
    int          last;
    logic [15:0] exp_dn;
    logic [7:0]  exp_dd;
    int          exp_id;
    logic [7:0]  exp_q;
    logic [7:0]  exp_r;
    bit          exp_dbz;
    bit          exp_ovf;
    int          first_rsp_cyc;
    logic [7:0]  first_rsp_q;
    logic [7:0]  first_rsp_r;
    bit          first_rsp_ovf;
    int          grants[$];

    function automatic bit any_pend();
        bit a = 1'b0;
        for (int i = 0; i < NREQ; i++) a |= pend[i];
        return a;
    endfunction

    task automatic drive(input bit rdy);
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = pend[i];
            req_n[16*i +: 16]   = pn[i];
            req_d[8*i +: 8]     = pd[i];
        end
        rsp_ready = rdy;
    endtask

    // One cycle: drive at the falling edge, check settled outputs, advance.
    task automatic tick(input bit rdy);
        int g;
        int obs_g;
        drive(rdy);
        #1;
        check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
        check("div_n", div_n, exp_dn);
        check("div_d", div_d, exp_dd);
        if (!busy) begin
            g = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && pend[(last + k) % NREQ]) g = (last + k) % NREQ;
            end
            check("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
            check("rsp_valid_idle", rsp_valid, 0);
            obs_g = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs_g = i;
            if (obs_g >= 0) grants.push_back(obs_g);
            if (g >= 0) begin
                busy    = 1'b1;
                last    = g;
                hs_cyc  = cyc;
                pend[g] = 1'b0;
                exp_id  = g;
                if (pd[g] == 8'd0) begin
                    exp_q   = 8'hFF;
                    exp_r   = pn[g][7:0];
                    exp_dbz = 1'b1;
                    exp_ovf = 1'b0;
                    rsp_at  = cyc + 1;
                end else begin
                    exp_q   = 8'((pn[g] / pd[g]) & 16'hFF);
                    exp_r   = 8'(pn[g] % pd[g]);
                    exp_dbz = 1'b0;
                    exp_ovf = (pn[g][15:8] >= pd[g]);
                    exp_dn  = pn[g];
                    exp_dd  = pd[g];
                    rsp_at  = cyc + LAT + 1;
                end
            end
        end else begin
            check("req_ready_busy", req_ready, 0);
            check("rsp_valid", rsp_valid, (cyc >= rsp_at));
            if (cyc >= rsp_at) begin
                check("rsp_id", rsp_id, exp_id);
                check("rsp_q", rsp_q, exp_q);
                check("rsp_r", rsp_r, exp_r);
                check("rsp_dbz", rsp_dbz, exp_dbz);
`ifdef DIV_ARB_OVF_CHECK_EN
                check("rsp_ovf", rsp_ovf, exp_ovf);
`endif
                if (cyc == rsp_at) begin
                    first_rsp_cyc = cyc;
                    first_rsp_q   = rsp_q;
                    first_rsp_r   = rsp_r;
                    first_rsp_ovf = exp_ovf;
`ifdef DIV_ARB_OVF_CHECK_EN
                    first_rsp_ovf = rsp_ovf;
`endif
                end
                if (rdy) busy = 1'b0;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n  = 1'b1;
        busy   = 1'b0;
        last   = NREQ - 1;
        exp_dn = '0;
        exp_dd = '0;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_q", rsp_q, 0);
        check("rst_rsp_r", rsp_r, 0);
        check("rst_rsp_dbz", rsp_dbz, 0);
        check("rst_div_n", div_n, 0);
        check("rst_div_d", div_d, 0);
`ifdef DIV_ARB_OVF_CHECK_EN
        check("rst_rsp_ovf", rsp_ovf, 0);
`endif
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((busy || any_pend()) && n < max) begin
            tick(1'b1);
            n++;
        end
        check("drain_timeout", 32'(busy || any_pend()), 0);
    endtask

    task automatic post(input int i, input logic [15:0] n, input logic [7:0] d);
        pend[i] = 1'b1;
        pn[i]   = n;
        pd[i]   = d;
    endtask

    initial begin
        int n;
        cyc = 0;
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            pn[i]   = '0;
            pd[i]   = '0;
        end
        drive(1'b0);
        @(negedge clk);
        do_reset();
        check("rst_req_ready", req_ready, 0);

        // Single normal division from requester 0.
        post(0, 16'd1000, 8'd7);
        drain(20);
        check("t1_latency", first_rsp_cyc - hs_cyc, LAT + 1);
        check("t1_q", first_rsp_q, 142);
        check("t1_r", first_rsp_r, 6);

        // All requesters pending after reset: rotate 0,1,2,3 then 0.
        do_reset();
        grants.delete();
        for (int i = 0; i < NREQ; i++) post(i, 16'(100 + i), 8'(3 + i));
        n = 0;
        while (grants.size() < 4 && n < 40) begin
            tick(1'b1);
            n++;
        end
        post(0, 16'd500, 8'd9);
        drain(40);
        check("t2_grant_cnt", grants.size(), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++) begin
            check("t2_grant", grants[i], i % NREQ);
        end

        // Divide by zero from requester 2.
        post(2, 16'h1234, 8'd0);
        drain(20);
        check("t3_latency", first_rsp_cyc - hs_cyc, 1);
        check("t3_q", first_rsp_q, 8'hFF);
        check("t3_r", first_rsp_r, 8'h34);

        // Backpressure on the response while requester 1 waits.
        post(3, 16'd4000, 8'd13);
        n = 0;
        while (!(busy && cyc >= rsp_at) && n < 20) begin
            tick(1'b1);
            n++;
        end
        post(1, 16'd77, 8'd5);
        repeat (5) tick(1'b0);
        grants.delete();
        tick(1'b1);
        tick(1'b1);
        check("t4_next_grant_cnt", grants.size(), 1);
        if (grants.size() > 0) check("t4_next_grant", grants[0], 1);
        drain(20);

        // Reset while BUSY discards the operation.
        post(1, 16'd999, 8'd5);
        tick(1'b1);
        tick(1'b1);
        do_reset();
        grants.delete();
        for (int i = 0; i < NREQ; i++) post(i, 16'(40 + i), 8'(2 + i));
        tick(1'b1);
        check("t5_grant_cnt", grants.size(), 1);
        if (grants.size() > 0) check("t5_grant", grants[0], 0);
        drain(40);

`ifdef DIV_ARB_OVF_CHECK_EN
        post(0, 16'h0800, 8'd4);
        drain(20);
        check("t6_ovf_set", first_rsp_ovf, 1);
        post(0, 16'h0300, 8'd4);
        drain(20);
        check("t6_ovf_clr", first_rsp_ovf, 0);
`endif

        // Random traffic.
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom % 3) == 0) begin
                    n = $urandom % 8;
                    post(i, 16'($urandom),
                         (n == 0) ? 8'd0 : (n == 1) ? 8'($urandom % 4 + 1)
                                                    : 8'($urandom));
                end else if (pend[i] && ($urandom % 20) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            tick(1'(($urandom % 4) != 0));
        end
        drain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
